// File: rtl/lsu_mem_port.sv
// Load/store unit bus port: one access in flight, word-aligned bus with byte
// enables, load lane select/extension and a REQ+WAIT timeout.
module lsu_mem_port #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_store,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic [1:0]  rsp_err,
   output logic        mem_req,
   input  logic        mem_gnt,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

   typedef struct packed {
      logic       store;
      logic [2:0] funct3;
      logic [1:0] lane;
   } lsu_req_t;

   localparam logic [1:0] ERR_OK  = 2'b00;
   localparam logic [1:0] ERR_MIS = 2'b01;
   localparam logic [1:0] ERR_ILL = 2'b10;
   localparam logic [1:0] ERR_TO  = 2'b11;

   state_t     state;
   lsu_req_t   q;
   logic [7:0] cnt;

   logic        illegal, misaligned, accept, timeout_hit;
   logic [3:0]  be_calc;
   logic [31:0] wdata_calc, load_fmt;
   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   assign accept  = req_valid & req_ready;
   assign illegal = req_store ? (req_funct3[2] | (req_funct3 == 3'b011))
                              : ((req_funct3 == 3'b011) | (req_funct3[2:1] == 2'b11));
   assign misaligned = ((req_funct3[1:0] == 2'b01) & req_addr[0]) |
                       ((req_funct3[1:0] == 2'b10) & (|req_addr[1:0]));

   // Counter holds cycles already spent in REQ+WAIT; this cycle is the next one.
   assign timeout_hit = ({1'b0, cnt} + 9'd1) >= 9'(TIMEOUT_CYCLES);

   always_comb begin
      be_calc    = 4'b1111;
      wdata_calc = req_wdata;
      case (req_funct3[1:0])
         2'b00: begin
            be_calc    = 4'b0001 << req_addr[1:0];
            wdata_calc = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            be_calc    = 4'b0011 << {req_addr[1], 1'b0};
            wdata_calc = {2{req_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   assign byte_lane = mem_rdata[{q.lane, 3'b000} +: 8];
   assign half_lane = mem_rdata[{q.lane[1], 4'b0000} +: 16];

   always_comb begin
      load_fmt = mem_rdata;
      case (q.funct3)
         3'b000:  load_fmt = {{24{byte_lane[7]}}, byte_lane};
         3'b001:  load_fmt = {{16{half_lane[15]}}, half_lane};
         3'b100:  load_fmt = {24'd0, byte_lane};
         3'b101:  load_fmt = {16'd0, half_lane};
         default: load_fmt = mem_rdata;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         q         <= '0;
         cnt       <= '0;
         req_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= ERR_OK;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_be    <= '0;
         mem_wdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  q         <= '{store: req_store, funct3: req_funct3, lane: req_addr[1:0]};
                  req_ready <= 1'b0;
                  cnt       <= '0;
                  if (illegal || misaligned) begin
                     rsp_err   <= illegal ? ERR_ILL : ERR_MIS;
                     rsp_valid <= 1'b1;
                     state     <= RESP;
                  end else begin
                     mem_req   <= 1'b1;
                     mem_we    <= req_store;
                     mem_addr  <= {req_addr[31:2], 2'b00};
                     mem_be    <= be_calc;
                     mem_wdata <= wdata_calc;
                     state     <= REQ;
                  end
               end else begin
                  req_ready <= 1'b1;
               end
            end
            REQ: begin
               cnt <= cnt + 8'd1;
               if (mem_gnt) begin
                  mem_req <= 1'b0;
                  state   <= WAIT;
               end else if (timeout_hit) begin
                  mem_req   <= 1'b0;
                  rsp_err   <= ERR_TO;
                  rsp_valid <= 1'b1;
                  state     <= RESP;
               end
            end
            WAIT: begin
               cnt <= cnt + 8'd1;
               if (mem_rvalid) begin
                  rsp_rdata <= q.store ? 32'd0 : load_fmt;
                  rsp_valid <= 1'b1;
                  state     <= RESP;
               end else if (timeout_hit) begin
                  rsp_err   <= ERR_TO;
                  rsp_valid <= 1'b1;
                  state     <= RESP;
               end
            end
            RESP: begin
               rsp_valid <= 1'b0;
               rsp_rdata <= '0;
               rsp_err   <= ERR_OK;
               req_ready <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed + random bench for lsu_mem_port against a cycle-timeline model
// derived from byte arithmetic and the timeout rules.
module tb_lsu_mem_port;
   localparam int TO = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_store;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_err;
   logic        mem_req, mem_gnt, mem_we, mem_rvalid;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_be;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   lsu_mem_port #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One access. gd = cycles of mem_req before gnt, rdly = cycles after gnt
   // before rvalid; stray pulses rvalid in RESP and the following IDLE.
   task automatic run(input bit st, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] rd,
                      input int gd, input int rdly, input bit stray);
      bit          ill, mis, bus;
      int          sz, off, g, rv, tw, rsp, req_end, w;
      logic [1:0]  e;
      logic [31:0] er, mask, v, ew;
      logic [3:0]  ebe;

      ill = st ? (f3 > 3'd2) : (f3 == 3'd3 || f3 > 3'd5);
      sz  = 1 << f3[1:0];
      mis = !ill && ((a % sz) != 0);
      bus = !ill && !mis;
      g   = 1 + gd;
      rv  = 0;
      req_end = 0;
      if (ill) begin e = 2'b10; rsp = 1; end
      else if (mis) begin e = 2'b01; rsp = 1; end
      else if (g > TO) begin e = 2'b11; rsp = TO + 1; req_end = TO; end
      else begin
         req_end = g;
         tw = (g + 1 > TO) ? g + 1 : TO;
         rv = g + 1 + rdly;
         if (rv <= tw) begin e = 2'b00; rsp = rv + 1; end
         else begin e = 2'b11; rsp = tw + 1; rv = 0; end
      end

      er = 32'd0; ebe = 4'd0; ew = 32'd0;
      if (bus) begin
         off  = ((a % 4) / sz) * sz;
         mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
         v    = (rd >> (8 * off)) & mask;
         if (!f3[2] && sz < 4 && v[8 * sz - 1]) v = v | ~mask;
         if (e == 2'b00 && !st) er = v;
         ebe = 4'(((1 << sz) - 1) << off);
         for (int i = 0; i < 4; i++) ew[8 * i +: 8] = wd[8 * (i % sz) +: 8];
      end

      w = 0;
      while (req_ready !== 1'b1 && w < 20) begin @(posedge clk); #1; w++; end
      chk("ready_wait", 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
      @(posedge clk);
      for (int k = 1; k <= rsp + 1; k++) begin
         #1;
         req_valid = 1'b0;
         req_addr  = $urandom;
         req_wdata = $urandom;
         chk($sformatf("mem_req@%0d", k), 32'(mem_req), 32'(bus && k <= req_end));
         chk($sformatf("rsp_valid@%0d", k), 32'(rsp_valid), 32'(k == rsp));
         chk($sformatf("req_ready@%0d", k), 32'(req_ready), 32'(k == rsp + 1));
         if (k == 1 && bus) begin
            chk("mem_addr", mem_addr, {a[31:2], 2'b00});
            chk("mem_be", 32'(mem_be), 32'(ebe));
            chk("mem_we", 32'(mem_we), 32'(st));
            if (st) chk("mem_wdata", mem_wdata, ew);
         end
         if (k == rsp) begin
            chk("rsp_err", 32'(rsp_err), 32'(e));
            chk("rsp_rdata", rsp_rdata, er);
         end
         mem_gnt    = bus && (g <= TO) && (k == g);
         mem_rvalid = (bus && rv != 0 && k == rv) || (stray && k >= rsp);
         mem_rdata  = (bus && k == rv) ? rd : $urandom;
         @(posedge clk);
      end
      #1;
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      if (stray) chk("stray_ignored", 32'(rsp_valid), 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1);
   end

   initial begin
      bit          st;
      logic [2:0]  f3;
      int          gd, rdly, w;
      logic [2:0]  ld_ok [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

      rst = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'd0;
      req_addr = 32'd0; req_wdata = 32'd0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
      #1;
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_mem_be", 32'(mem_be), 32'd0);
      chk("rst_rsp_err", 32'(rsp_err), 32'd0);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // Test plan directed steps
      run(1'b0, 3'b000, 32'h0000_1003, 32'h0, 32'h80AA_BBCC, 0, 0, 1'b0);
      run(1'b0, 3'b101, 32'h0000_2002, 32'h0, 32'hBEEF_1234, 0, 0, 1'b0);
      run(1'b0, 3'b001, 32'h0000_2002, 32'h0, 32'hBEEF_1234, 0, 0, 1'b0);
      run(1'b1, 3'b001, 32'h0000_3002, 32'h0000_ABCD, 32'h5A5A_5A5A, 0, 0, 1'b0);
      run(1'b0, 3'b010, 32'h0000_4001, 32'h0, 32'h0, 0, 0, 1'b0);
      run(1'b0, 3'b011, 32'h0000_4000, 32'h0, 32'h0, 0, 0, 1'b0);
      run(1'b1, 3'b011, 32'h0000_4001, 32'h0, 32'h0, 0, 0, 1'b0);
      run(1'b0, 3'b010, 32'h0000_7000, 32'h0, 32'h0, 30, 0, 1'b1);
      run(1'b0, 3'b010, 32'h0000_7004, 32'h0, 32'hCAFE_F00D, 0, 0, 1'b0);
      // Limit boundaries: gnt/rvalid on the limit cycle win, one later loses
      run(1'b0, 3'b100, 32'h0000_7101, 32'h0, 32'h0000_F100, 7, 0, 1'b0);
      run(1'b0, 3'b100, 32'h0000_7101, 32'h0, 32'h0000_F100, 7, 1, 1'b0);
      run(1'b1, 3'b000, 32'h0000_7202, 32'h0000_00E7, 32'h0, 0, 6, 1'b0);
      run(1'b1, 3'b000, 32'h0000_7202, 32'h0000_00E7, 32'h0, 0, 7, 1'b1);

      // Reset while in REQ, then while in WAIT
      w = 0;
      while (req_ready !== 1'b1 && w < 20) begin @(posedge clk); #1; w++; end
      req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0000_6000;
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("pre_rst_mem_req", 32'(mem_req), 32'd1);
      #2 rst = 1'b1;
      #1 chk("rst_req_drop", 32'(mem_req), 32'd0);
      @(posedge clk); #1 rst = 1'b0;
      w = 0;
      while (req_ready !== 1'b1 && w < 20) begin @(posedge clk); #1; w++; end
      req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0000_6000;
      @(posedge clk); #1;
      req_valid = 1'b0; mem_gnt = 1'b1;
      @(posedge clk); #1;
      mem_gnt = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("rst_wait_mem_req", 32'(mem_req), 32'd0);
      chk("rst_wait_req_ready", 32'(req_ready), 32'd0);
      chk("rst_wait_rsp_valid", 32'(rsp_valid), 32'd0);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1111_1111;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         mem_rvalid = 1'b0;
         chk("no_rsp_after_rst", 32'(rsp_valid), 32'd0);
      end
      run(1'b1, 3'b010, 32'h0000_5000, 32'h1234_5678, 32'h0, 0, 0, 1'b0);

      // Random accesses
      for (int n = 0; n < 80; n++) begin
         st = 1'($urandom % 2);
         if ($urandom % 5 == 0) f3 = 3'($urandom % 8);
         else f3 = st ? 3'($urandom % 3) : ld_ok[$urandom % 5];
         gd   = ($urandom % 8 == 0) ? int'($urandom_range(5, 10)) : int'($urandom % 3);
         rdly = ($urandom % 8 == 0) ? int'($urandom_range(4, 9)) : int'($urandom % 3);
         run(st, f3, $urandom, $urandom, $urandom, gd, rdly, ($urandom % 4) == 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
